data_mem_responder: RTL and testbench

- Responder side of the CPU data-memory interface.
- Accepts one load/store request at a time from the pipeline memory stage: the address is the ALU result and the store data is the forwarded rt value.
- Performs the access on an internal word-organised RAM after a configurable wait and returns aligned, extended read data.
- Drives a busy/stall signal to the hazard unit while an access is outstanding.

---
 rtl/data_mem_responder_if.sv | 33 +++
 rtl/data_mem_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
//------------------------------------------------------------------------------
// Module      : data_mem_responder_if
// Description : Request/response bundle between the pipeline memory stage
//               (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_addr_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_addr_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_addr_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : data_mem_responder
// Description : Data-memory responder. Accepts one load/store at a time,
//               waits WAIT_CYCLES, accesses an internal word RAM with
//               little-endian byte lanes and returns extended read data.
//               Optional macro DMEM_ALIGN_TRAP_EN: flag misaligned and
//               illegal-size accesses instead of force-aligning them.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  data_mem_responder_if.slave bus
);

  // Out-of-range wait counts simply keep their low four bits.
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;

  logic                  write_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [ADDR_W+1:0]     addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;

  logic [31:0]           mem_q [0:(1<<ADDR_W)-1];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_eff_write;
  logic [1:0]            w_eff_size;
  logic                  w_eff_signed;
  logic [ADDR_W+1:0]     w_eff_addr;
  logic [31:0]           w_eff_wdata;
  logic [1:0]            w_size_n;
  logic                  w_err;
  logic [ADDR_W-1:0]     w_idx;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [3:0]            w_be;
  logic [31:0]           w_wlane;
  logic                  w_unused_addr;

  assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];
  assign w_accept      = (state_q == S_IDLE) && bus.req_valid;
  // A pending access that meets reset never reaches the RAM or response regs.
  assign w_enter_resp  = (state_d == S_RESP) && !reset;

  // Select the request being completed: live inputs when going straight from
  // IDLE to RESP (zero wait), otherwise the copy latched on accept.
  always_comb begin
    w_eff_write  = write_q;
    w_eff_size   = size_q;
    w_eff_signed = signed_q;
    w_eff_addr   = addr_q;
    w_eff_wdata  = wdata_q;
    if (state_q == S_IDLE) begin
      w_eff_write  = bus.req_write;
      w_eff_size   = bus.req_size;
      w_eff_signed = bus.req_signed;
      w_eff_addr   = bus.req_addr[ADDR_W+1:0];
      w_eff_wdata  = bus.req_wdata;
    end
  end

  // Size normalisation and error detection. Force-alignment needs no extra
  // logic: halfword lanes only look at addr[1], word accesses ignore addr[1:0].
  always_comb begin
    w_size_n = w_eff_size;
`ifdef DMEM_ALIGN_TRAP_EN
    w_err = (w_eff_size == 2'b11) ||
            ((w_eff_size == 2'b01) && w_eff_addr[0]) ||
            ((w_eff_size == 2'b10) && (w_eff_addr[1:0] != 2'b00));
`else
    w_err = 1'b0;
    if (w_eff_size == 2'b11) begin
      w_size_n = 2'b10;
    end
`endif
  end

  // Lane selection for loads and stores.
  assign w_idx  = w_eff_addr[ADDR_W+1:2];
  assign w_word = mem_q[w_idx];
  assign w_byte = w_word[{w_eff_addr[1:0], 3'b000} +: 8];
  assign w_half = w_eff_addr[1] ? w_word[31:16] : w_word[15:0];

  // Extract/extend load data and build store byte enables and lane data.
  always_comb begin
    w_load  = w_word;
    w_be    = 4'b1111;
    w_wlane = w_eff_wdata;
    case (w_size_n)
      2'b00: begin
        w_load  = w_eff_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        w_be    = 4'b0001 << w_eff_addr[1:0];
        w_wlane = {4{w_eff_wdata[7:0]}};
      end
      2'b01: begin
        w_load  = w_eff_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        w_be    = w_eff_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_eff_wdata[15:0]}};
      end
      default: begin
        w_load  = w_word;
        w_be    = 4'b1111;
        w_wlane = w_eff_wdata;
      end
    endcase
  end

  // FSM next state, wait counter and handshake outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = bus.req_valid;
        if (w_accept) begin
          if (C_WAIT != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = C_WAIT - 4'd1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        bus.busy = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on accept so the pipeline may move on.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (w_accept) begin
      write_q  <= bus.req_write;
      size_q   <= bus.req_size;
      signed_q <= bus.req_signed;
      addr_q   <= bus.req_addr[ADDR_W+1:0];
      wdata_q  <= bus.req_wdata;
    end
  end

  // Response data: load result, or zero for stores and faulting accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else if (w_enter_resp) begin
      rdata_q <= (w_err || w_eff_write) ? 32'd0 : w_load;
    end
  end

  // Store commit on the edge entering RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_eff_write && !w_err) begin
      if (w_be[0]) mem_q[w_idx][7:0]   <= w_wlane[7:0];
      if (w_be[1]) mem_q[w_idx][15:8]  <= w_wlane[15:8];
      if (w_be[2]) mem_q[w_idx][23:16] <= w_wlane[23:16];
      if (w_be[3]) mem_q[w_idx][31:24] <= w_wlane[31:24];
    end
  end

  assign bus.resp_rdata = rdata_q;

`ifdef DMEM_ALIGN_TRAP_EN
  logic err_q;

  // Error flag for the access being answered.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (w_enter_resp) begin
      err_q <= w_err;
    end
  end

  assign bus.resp_addr_err = (state_q == S_RESP) && err_q;
`else
  assign bus.resp_addr_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Two instances
//               (wait 1 and wait 3) share one stimulus driver; a byte-level
//               memory model predicts every response and handshake output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        r_valid;
  int          sel;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();

  assign ifa.req_valid  = r_valid && (sel == 0);
  assign ifa.req_write  = r_write;
  assign ifa.req_size   = r_size;
  assign ifa.req_signed = r_signed;
  assign ifa.req_addr   = r_addr;
  assign ifa.req_wdata  = r_wdata;
  assign ifb.req_valid  = r_valid && (sel == 1);
  assign ifb.req_write  = r_write;
  assign ifb.req_size   = r_size;
  assign ifb.req_signed = r_signed;
  assign ifb.req_addr   = r_addr;
  assign ifb.req_wdata  = r_wdata;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa)
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Byte-addressed model of both RAMs (1024 words = 4096 bytes each).
  logic [7:0] mb [2][4096];

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic void model_access(input int d, input bit wr, input logic [1:0] sz_in,
                                       input bit sg, input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output bit err);
    logic [11:0] b;
    logic [1:0]  sz;
    int          n;
    b   = a[11:0];
    sz  = sz_in;
    err = 1'b0;
    rd  = 32'd0;
`ifdef DMEM_ALIGN_TRAP_EN
    err = (sz == 2'b11) || (sz == 2'b01 && b[0]) || (sz == 2'b10 && b[1:0] != 2'b00);
`else
    if (sz == 2'b11) sz = 2'b10;
    if (sz == 2'b01) b[0] = 1'b0;
    if (sz == 2'b10) b[1:0] = 2'b00;
`endif
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < n; i++) mb[d][int'(b) + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rd = rd | (32'(mb[d][int'(b) + i]) << (8*i));
      if (sg && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
    end
  endfunction

  // Expectation shared between driver and monitor.
  bit          mon_en;
  bit          pending;
  int          req_cyc;
  int          exp_cyc;
  logic [31:0] exp_rd;
  bit          exp_err;
  logic [31:0] last_rd [2];

  // Compare process: every cycle, both instances, against the model.
  always @(negedge clk) begin : p_monitor
    logic        mine;
    logic        o_valid, o_ready, o_busy, o_err;
    logic [31:0] o_rd;
    #1;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        mine    = pending && (sel == d);
        o_valid = (d == 0) ? ifa.resp_valid    : ifb.resp_valid;
        o_ready = (d == 0) ? ifa.req_ready     : ifb.req_ready;
        o_busy  = (d == 0) ? ifa.busy          : ifb.busy;
        o_err   = (d == 0) ? ifa.resp_addr_err : ifb.resp_addr_err;
        o_rd    = (d == 0) ? ifa.resp_rdata    : ifb.resp_rdata;
        chk($sformatf("d%0d_ready", d), 32'(o_ready), 32'(!mine || cyc == req_cyc));
        chk($sformatf("d%0d_busy", d),  32'(o_busy),  32'(mine && cyc < exp_cyc));
        chk($sformatf("d%0d_valid", d), 32'(o_valid), 32'(mine && cyc == exp_cyc));
        if (mine && cyc == exp_cyc) begin
          chk($sformatf("d%0d_rdata", d), o_rd, exp_rd);
          chk($sformatf("d%0d_err", d), 32'(o_err), 32'(exp_err));
          last_rd[d] = exp_rd;
        end else begin
          chk($sformatf("d%0d_rdata_hold", d), o_rd, last_rd[d]);
          chk($sformatf("d%0d_err_idle", d), 32'(o_err), 32'd0);
        end
      end
    end
  end

  // One complete access; entered and left just after a falling edge.
  task automatic access(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got_rd, output bit got_err);
    logic [31:0] m_rd;
    bit          m_err;
    sel      = d;
    r_valid  = 1'b1;
    r_write  = wr;
    r_size   = sz;
    r_signed = sg;
    r_addr   = a;
    r_wdata  = wd;
    model_access(d, wr, sz, sg, a, wd, m_rd, m_err);
    exp_rd   = m_rd;
    exp_err  = m_err;
    req_cyc  = cyc;
    exp_cyc  = cyc + wait_of(d) + 1;
    pending  = 1'b1;
    @(negedge clk);
    r_valid  = 1'b0;
    r_write  = 1'($urandom);
    r_size   = 2'($urandom);
    r_signed = 1'($urandom);
    r_addr   = $urandom;
    r_wdata  = $urandom;
    while (cyc < exp_cyc) @(negedge clk);
    #2;
    got_rd  = (d == 0) ? ifa.resp_rdata : ifb.resp_rdata;
    got_err = (d == 0) ? ifa.resp_addr_err : ifb.resp_addr_err;
    @(negedge clk);
    pending = 1'b0;
  endtask

  initial begin : p_main
    logic [31:0] rd;
    bit          er;
    logic [31:0] r;
    rst = 1'b1; r_valid = 1'b0; sel = 0;
    r_write = 1'b0; r_size = 2'b00; r_signed = 1'b0; r_addr = '0; r_wdata = '0;
    mon_en = 1'b0; pending = 1'b0; req_cyc = -1; exp_cyc = -1;
    exp_rd = '0; exp_err = 1'b0; last_rd[0] = '0; last_rd[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_valid0", 32'(ifa.resp_valid), 32'd0);
    chk("rst_rdata0", ifa.resp_rdata, 32'd0);
    chk("rst_ready0", 32'(ifa.req_ready), 32'd1);
    chk("rst_busy0",  32'(ifa.busy), 32'd0);
    chk("rst_valid1", 32'(ifb.resp_valid), 32'd0);
    chk("rst_ready1", 32'(ifb.req_ready), 32'd1);
    @(negedge clk);
    mon_en = 1'b1;

    // Give every word used by the bench a known value.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 32; w++)
        access(d, 1'b1, 2'b10, 1'b0, 32'(w) << 2,
               (d == 1 && w == 16) ? 32'h0BADC0DE : $urandom, rd, er);

    // Directed cases on the one-wait instance.
    access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    chk("sw_rdata_zero", rd, 32'd0);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    chk("lw_10", rd, 32'hDEADBEEF);
    access(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, er);
    chk("lb_11", rd, 32'hFFFFFFBE);
    access(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, er);
    chk("lbu_11", rd, 32'h000000BE);
    access(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er);
    chk("lh_12", rd, 32'hFFFFDEAD);
    access(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er);
    chk("lhu_12", rd, 32'h0000DEAD);
    access(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF55, rd, er);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    chk("lw_after_sb", rd, 32'h55ADBEEF);

    access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A51111, rd, er);
    access(0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, rd, er);
`ifdef DMEM_ALIGN_TRAP_EN
    chk("sh_21_err", 32'(er), 32'd1);
    chk("sh_21_rdata", rd, 32'd0);
    access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    chk("lw_20_unchanged", rd, 32'hA5A51111);
`else
    chk("sh_21_err", 32'(er), 32'd0);
    access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    chk("lw_20_aligned_sh", rd, 32'hA5A51234);
`endif

    access(0, 1'b1, 2'b10, 1'b0, 32'h1004, 32'h12345678, rd, er);
    access(0, 1'b0, 2'b10, 1'b0, 32'h0004, 32'h0, rd, er);
    chk("lw_wrap", rd, 32'h12345678);

    // Reset one cycle after accepting a store on the three-wait instance.
    mon_en   = 1'b0;
    sel      = 1;
    r_valid  = 1'b1;
    r_write  = 1'b1;
    r_size   = 2'b10;
    r_signed = 1'b0;
    r_addr   = 32'h40;
    r_wdata  = 32'hCAFEF00D;
    @(negedge clk);
    r_valid = 1'b0;
    #1;
    chk("mid_busy", 32'(ifb.busy), 32'd1);
    chk("mid_ready", 32'(ifb.req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("abort_valid", 32'(ifb.resp_valid), 32'd0);
      chk("abort_ready", 32'(ifb.req_ready), 32'd1);
      chk("abort_rdata", ifb.resp_rdata, 32'd0);
      @(negedge clk);
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    mon_en = 1'b1;
    access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er);
    chk("lw_40_old", rd, 32'h0BADC0DE);

    // Randomized traffic on both instances over the initialized words.
    for (int t = 0; t < 300; t++) begin
      r = $urandom;
      access(int'($urandom_range(1, 0)), 1'($urandom), 2'($urandom), 1'($urandom),
             (r & 32'hFFFFF000) | (32'($urandom_range(31, 0)) << 2) | 32'($urandom_range(3, 0)),
             $urandom, rd, er);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
